// File: rtl/pwm_audio_pkg.sv
// Shared types and constants for the PWM audio sink and its sample FIFO.
package pwm_audio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } pwm_state_t;

    localparam int DEFAULT_CTR_SIZE   = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Occupancy needs one extra bit so that a completely full FIFO is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with occupancy count; DEPTH must be a power of two, at least 2.
// Pointers wrap naturally; a push while full or a pop while empty is ignored.
module sample_fifo
    import pwm_audio_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CTR_SIZE,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int LW   = level_width(DEPTH),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // A simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM DAC sample sink: buffers samples in a FIFO and plays one per 2^CTR_SIZE-clock period.
// Define PWM_AUDIO_SIGNED_EN to accept two's-complement samples (MSB flipped on write).
module pwm_audio_out
    import pwm_audio_pkg::*;
#(
    parameter int CTR_SIZE   = DEFAULT_CTR_SIZE,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [CTR_SIZE-1:0]                 sample_in,
    input  logic                                sample_valid,
    output logic                                sample_ready,
    output logic                                pwm_out,
    output logic                                underrun,
    input  logic                                underrun_clr,
    output logic [level_width(FIFO_DEPTH)-1:0]  fifo_level
);

    localparam logic [CTR_SIZE-1:0] CTR_MAX = '1;

    pwm_state_t          state;
    pwm_state_t          state_next;
    logic [CTR_SIZE-1:0] ctr_q;
    logic [CTR_SIZE-1:0] ctr_next;
    logic [CTR_SIZE-1:0] duty_q;
    logic [CTR_SIZE-1:0] duty_next;
    logic [CTR_SIZE-1:0] write_data;
    logic [CTR_SIZE-1:0] fifo_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                underrun_set;

`ifdef PWM_AUDIO_SIGNED_EN
    assign write_data = {~sample_in[CTR_SIZE-1], sample_in[CTR_SIZE-2:0]};
`else
    assign write_data = sample_in;
`endif

    // Ready looks only at the registered level, so a full FIFO holds off a write for a cycle.
    assign sample_ready = !fifo_full;
    assign push         = sample_valid && sample_ready;

    sample_fifo #(
        .WIDTH (CTR_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (write_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Enable is only honoured at the wrap, so a period always finishes; no sample is consumed then.
    always_comb begin
        state_next   = state;
        ctr_next     = ctr_q;
        duty_next    = duty_q;
        pop          = 1'b0;
        underrun_set = 1'b0;
        case (state)
            IDLE: begin
                ctr_next = '0;
                if (enable) state_next = PRIME;
            end
            PRIME: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    duty_next  = fifo_data;
                    ctr_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                ctr_next = ctr_q + CTR_SIZE'(1);
                if (ctr_q == CTR_MAX) begin
                    if (!enable) begin
                        state_next = IDLE;
                    end else if (!fifo_empty) begin
                        pop       = 1'b1;
                        duty_next = fifo_data;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ctr_q    <= '0;
            duty_q   <= '0;
            pwm_out  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state   <= state_next;
            ctr_q   <= ctr_next;
            duty_q  <= duty_next;
            pwm_out <= (state == RUN) && (ctr_q < duty_q);
            if (underrun_set)      underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Scoreboard bench for pwm_audio_out: stimulus queues expected duties, a monitor checks each PWM period.
module tb_pwm_audio_out;
    import pwm_audio_pkg::*;

    localparam int CTR_SIZE   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PERIOD     = 1 << CTR_SIZE;
    localparam int LW         = level_width(FIFO_DEPTH);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                enable = 1'b0;
    logic [CTR_SIZE-1:0] sample_in = '0;
    logic                sample_valid = 1'b0;
    logic                sample_ready;
    logic                pwm_out;
    logic                underrun;
    logic                underrun_clr = 1'b0;
    logic [LW-1:0]       fifo_level;

    int total = 0;
    int bad   = 0;

    // Expected duty of every sample accepted but not yet played.
    logic [CTR_SIZE-1:0] exp_q[$];
    int mon_windows = 0;
    int win_idx     = -1;
    int win_pos     = -1;

    pwm_audio_out #(
        .CTR_SIZE   (CTR_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [CTR_SIZE-1:0] to_duty(input logic [CTR_SIZE-1:0] s);
`ifdef PWM_AUDIO_SIGNED_EN
        return s + (CTR_SIZE'(1) << (CTR_SIZE - 1));
`else
        return s;
`endif
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out, got no response, wanted one", name);
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst          = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with sample_valid still high.
    task automatic apply_stimulus(input logic [CTR_SIZE-1:0] value);
        int waited = 0;
        sample_in    = value;
        sample_valid = 1'b1;
        while (!sample_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!sample_ready) begin
            report_timeout("push_handshake");
        end else begin
            @(posedge clk);
            exp_q.push_back(to_duty(value));
            @(negedge clk);
        end
    endtask

    task automatic wait_monitor(input int budget);
        int n = 0;
        while (mon_windows > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (mon_windows > 0) begin
            report_timeout("monitor_done");
            finish_run();
        end
    endtask

    // Finds the first pop as a level drop, then checks consecutive whole periods against the queue.
    task automatic run_monitor();
        int prev;
        int waited;
        int highs;
        int errs;
        bit started;
        bit ur_model;
        logic [CTR_SIZE-1:0] duty;
        prev     = int'(fifo_level);
        waited   = 0;
        started  = 1'b0;
        ur_model = 1'b0;
        duty     = '0;
        while (!started && waited < 4000) begin
            @(negedge clk);
            waited++;
            if (int'(fifo_level) < prev) started = 1'b1;
            prev = int'(fifo_level);
        end
        if (!started) begin
            report_timeout("first_pop");
            mon_windows = 0;
            return;
        end
        for (int w = 0; w < mon_windows; w++) begin
            if (exp_q.size() > 0) duty = exp_q.pop_front();
            else                  ur_model = 1'b1;
            highs = 0;
            errs  = 0;
            for (int p = 0; p < PERIOD; p++) begin
                @(negedge clk);
                win_idx = w;
                win_pos = p;
                if (p == 0) check_output($sformatf("underrun_w%0d", w), int'(underrun), int'(ur_model));
                if (pwm_out === 1'b1) highs++;
                if (pwm_out !== (p < int'(duty))) errs++;
            end
            check_output($sformatf("highs_w%0d", w), highs, int'(duty));
            check_output($sformatf("shape_errs_w%0d", w), errs, 0);
        end
        win_idx     = -1;
        win_pos     = -1;
        mon_windows = 0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_windows > 0) run_monitor();
        end
    end

    initial begin : watchdog
        #1500000;
        report_timeout("global_watchdog");
        finish_run();
    end

    initial begin : main
        int cnt_a;
        int cnt_b;
        int n;
        logic [CTR_SIZE-1:0] v;
        logic [CTR_SIZE-1:0] vals [5];

        do_reset();
        check_output("reset_level", int'(fifo_level), 0);
        check_output("reset_ready", int'(sample_ready), 1);
        check_output("reset_pwm", int'(pwm_out), 0);
        check_output("reset_underrun", int'(underrun), 0);

        // Enabled with no samples: stays primed, silent, no underrun.
        enable = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        repeat (1000) begin
            @(negedge clk);
            if (pwm_out !== 1'b0) cnt_a++;
            if (underrun !== 1'b0) cnt_b++;
        end
        check_output("prime_pwm_high_cycles", cnt_a, 0);
        check_output("prime_underrun_cycles", cnt_b, 0);

        // Three directed duties in consecutive periods.
        do_reset();
        apply_stimulus(8'h40);
        apply_stimulus(8'h80);
        apply_stimulus(8'hFF);
        sample_valid = 1'b0;
        mon_windows  = 3;
        enable       = 1'b1;
        wait_monitor(3 * PERIOD + 600);
        check_output("underrun_after_drain", int'(underrun), 1);
        enable = 1'b0;
        repeat (300) @(negedge clk);
        cnt_a = 0;
        repeat (100) begin
            @(negedge clk);
            if (pwm_out !== 1'b0) cnt_a++;
        end
        check_output("idle_pwm_high_cycles", cnt_a, 0);
        check_output("underrun_sticky_idle", int'(underrun), 1);

        // Five back-to-back writes into a 4-deep FIFO while idle.
        do_reset();
        for (int i = 0; i < 5; i++) vals[i] = CTR_SIZE'($urandom_range(0, PERIOD - 1));
        for (int i = 0; i < 4; i++) apply_stimulus(vals[i]);
        check_output("full_level", int'(fifo_level), FIFO_DEPTH);
        check_output("full_ready", int'(sample_ready), 0);
        fork
            begin
                apply_stimulus(vals[4]);
                sample_valid = 1'b0;
            end
        join_none
        cnt_a = 0;
        cnt_b = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample_ready !== 1'b0) cnt_a++;
            if (int'(fifo_level) != FIFO_DEPTH) cnt_b++;
        end
        check_output("held_ready_cycles", cnt_a, 0);
        check_output("held_level_changes", cnt_b, 0);
        mon_windows = 5;
        enable      = 1'b1;
        wait_monitor(5 * PERIOD + 600);

        // Randomized stream kept ahead of the player.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v = CTR_SIZE'($urandom_range(0, PERIOD - 1));
            apply_stimulus(v);
        end
        sample_valid = 1'b0;
        mon_windows  = 10;
        enable       = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v = CTR_SIZE'($urandom_range(0, PERIOD - 1));
            apply_stimulus(v);
        end
        sample_valid = 1'b0;
        wait_monitor(10 * PERIOD + 600);

        // Single sample repeated through underruns, then cleared.
        do_reset();
        apply_stimulus(8'h10);
        sample_valid = 1'b0;
        mon_windows  = 3;
        enable       = 1'b1;
        wait_monitor(3 * PERIOD + 600);
        check_output("underrun_set", int'(underrun), 1);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check_output("underrun_cleared", int'(underrun), 0);
        repeat (100) @(negedge clk);
        check_output("underrun_stays_clear", int'(underrun), 0);
        repeat (200) @(negedge clk);
        check_output("underrun_reasserted", int'(underrun), 1);
        enable = 1'b0;

        // Enable dropped mid-period: the period completes, then idle without underrun.
        do_reset();
        apply_stimulus(8'h30);
        apply_stimulus(8'h60);
        sample_valid = 1'b0;
        mon_windows  = 2;
        enable       = 1'b1;
        n = 0;
        while (!(win_idx == 1 && win_pos == 32) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) report_timeout("reach_ctr_0x20");
        @(negedge clk);
        enable = 1'b0;
        wait_monitor(2 * PERIOD + 600);
        cnt_a = 0;
        repeat (300) begin
            @(negedge clk);
            if (pwm_out !== 1'b0) cnt_a++;
        end
        check_output("after_disable_pwm_high_cycles", cnt_a, 0);
        check_output("after_disable_underrun", int'(underrun), 0);
        check_output("after_disable_level", int'(fifo_level), 0);

        // Asynchronous reset while the pin is high.
        do_reset();
        apply_stimulus(8'hC0);
        apply_stimulus(8'hC0);
        sample_valid = 1'b0;
        enable       = 1'b1;
        n = 0;
        while (pwm_out !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (pwm_out !== 1'b1) report_timeout("pwm_high_before_reset");
        #2;
        rst = 1'b0;
        #1;
        check_output("async_reset_pwm", int'(pwm_out), 0);
        check_output("async_reset_level", int'(fifo_level), 0);
        check_output("async_reset_ready", int'(sample_ready), 1);
        exp_q.delete();
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;

`ifdef PWM_AUDIO_SIGNED_EN
        // Most negative sample is silence, zero is mid-scale.
        do_reset();
        apply_stimulus(8'h80);
        apply_stimulus(8'h00);
        sample_valid = 1'b0;
        mon_windows  = 2;
        enable       = 1'b1;
        wait_monitor(2 * PERIOD + 600);
        enable = 1'b0;
`endif

        finish_run();
    end

endmodule
